// File: rtl/mdu_sequencer.sv
// HI/LO owner and mult/div sequencer beside the E-stage ALU; results land MULT_CYCLES/DIV_CYCLES edges after start.
// No handshake: md_stall holds any MDU op in D while busy, and req (flush) suppresses every HI/LO side effect.
module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic        req,
  input  logic        D_is_md,
  output logic        busy,
  output logic        start,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      hi_tmp, lo_tmp;
  logic             div_zero;

  logic             is_mul, is_div, rt_zero, commit;
  logic             hi_we, lo_we;
  logic [31:0]      hi_nxt, lo_nxt;
  logic [63:0]      prod_s, prod_u;
  logic [31:0]      quo_s, rem_s, quo_u, rem_u;
  logic [31:0]      res_hi, res_lo;

  assign is_mul  = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU);
  assign is_div  = (E_md_op == OP_DIV)  || (E_md_op == OP_DIVU);
  assign rt_zero = (E_rt_val == 32'd0);

  // Result is computed in E and parked in the tmp regs; the counter only models latency.
  always_comb begin
    prod_s = {{32{E_rs_val[31]}}, E_rs_val} * {{32{E_rt_val[31]}}, E_rt_val};
    prod_u = {32'd0, E_rs_val} * {32'd0, E_rt_val};
    quo_s  = 32'd0;
    rem_s  = 32'd0;
    quo_u  = 32'd0;
    rem_u  = 32'd0;
    if (!rt_zero) begin
      quo_s = $signed(E_rs_val) / $signed(E_rt_val);
      rem_s = $signed(E_rs_val) % $signed(E_rt_val);
      quo_u = E_rs_val / E_rt_val;
      rem_u = E_rs_val % E_rt_val;
    end
    unique case (E_md_op)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin res_hi = rem_s;         res_lo = quo_s;        end
      OP_DIVU:  begin res_hi = rem_u;         res_lo = quo_u;        end
      default:  begin res_hi = 32'd0;         res_lo = 32'd0;        end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_tmp   <= 32'd0;
      lo_tmp   <= 32'd0;
      div_zero <= 1'b0;
      HI       <= 32'd0;
      LO       <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (start) begin
        hi_tmp   <= res_hi;
        lo_tmp   <= res_lo;
        div_zero <= is_div && rt_zero;
      end
      if (hi_we) HI <= hi_nxt;
      if (lo_we) LO <= lo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      RUN: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = IDLE;
      end
    endcase
  end

  // mthi/mtlo and a retiring op cannot coincide: the moves require !busy.
  always_comb begin
    busy     = (cnt != '0);
    start    = (is_mul || is_div) && !busy && !req;
    md_stall = D_is_md && (start || busy);
    commit   = (state == RUN) && (cnt == CNT_ONE) && !div_zero;
    hi_we    = commit || ((E_md_op == OP_MTHI) && !busy && !req);
    lo_we    = commit || ((E_md_op == OP_MTLO) && !busy && !req);
    hi_nxt   = commit ? hi_tmp : E_rs_val;
    lo_nxt   = commit ? lo_tmp : E_rs_val;
    unique case (E_md_op)
      OP_MFHI: E_md_out = HI;
      OP_MFLO: E_md_out = LO;
      default: E_md_out = 32'd0;
    endcase
  end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multiply/divide sequencer for the five-stage MIPS pipeline. It sits beside the E-stage ALU, owns the HI/LO registers, and launches mult/multu/div/divu operations with fixed multi-cycle latency. It serves mfhi/mflo/mthi/mtlo and produces the MDU stall term that the hazard unit ORs into the global D-stage stall. Operations are gated by the CP0 exception/interrupt request so a flushed E-stage instruction never touches HI/LO.

## Interface
- MULT_CYCLES, 5: busy cycles after a mult/multu start
- DIV_CYCLES, 10: busy cycles after a div/divu start
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- E_md_op  in  4  E-stage MDU opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 treated as none
- E_rs_val  in  32  forwarded rs value in E
- E_rt_val  in  32  forwarded rt value in E
- req  in  1  exception/interrupt taken this cycle; E instruction is being flushed
- D_is_md  in  1  D-stage instruction is any MDU opcode (1–8)
- busy  out  1  operation in flight
- start  out  1  combinational: (E_md_op in 1..4) & !busy & !req
- md_stall  out  1  D_is_md & (start | busy)
- HI  out  32  architectural HI
- LO  out  32  architectural LO
- E_md_out  out  32  mfhi → HI, mflo → LO, else 0; combinational

## Operation
- States: IDLE (cnt==0, busy=0), RUN (cnt>0, busy=1). busy = (cnt != 0).
- IDLE, start=1: latch result into hi_tmp/lo_tmp, load cnt with MULT_CYCLES or DIV_CYCLES, and record div_zero. Move to RUN.
- RUN: cnt decrements each edge. On the edge where cnt goes 1→0, HI/LO take hi_tmp/lo_tmp, unless div_zero is set. Return to IDLE.
- mult: {hi_tmp,lo_tmp} = $signed(rs) * $signed(rt), full 64-bit. multu: same, unsigned.
- div: lo_tmp = signed quotient, truncated toward zero; hi_tmp = remainder, sign of dividend. divu: unsigned.
- Divisor 0 (div/divu): still busy DIV_CYCLES; HI and LO keep their old values.
- mthi/mtlo: HI (resp. LO) ← E_rs_val at the edge, only when !busy & !req. No busy.
- While busy, any E_md_op is ignored. Correct pipelines never present one, because md_stall holds it in D.
- req=1 blocks start/mthi/mtlo in the same cycle. An operation already in RUN when req rises continues to completion.
- mfhi/mflo read current HI/LO combinationally; the stall guarantees they never observe RUN.
- Reset, asynchronous, including mid-RUN: cnt=0, busy=0, HI=LO=0, tmp regs=0, div_zero=0. The in-flight result is discarded.

## Timing
- Cycle 0: multiply op in E, start=1, md_stall=D_is_md.
- Edge 0: cnt←MULT_CYCLES; busy=1 in cycles 1..MULT_CYCLES (5).
- HI/LO carry the new value from cycle MULT_CYCLES+1 (6). Divide: busy cycles 1..10, new value from cycle 11.
- Back-to-back: an MDU op in D during cycle 0..5 stalls. It enters E in cycle 6 at the earliest, sees busy=0, and sees the updated HI/LO.
- mthi/mtlo result is visible the cycle after the write edge.
- Reset outputs: busy=0, start=0 unless E_md_op/req dictate, md_stall per formula, HI=LO=0, E_md_out=0 for op≠7/8.

## Test plan
- mult, rs=0xFFFFFFFE (-2), rt=3. Required: busy for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu, same operands. Required: HI=0x00000002, LO=0xFFFFFFFA, valid at cycle 6.
- div rs=-7, rt=2. Required: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1), valid at cycle 11. Then divu 7/0. Required: 10 busy cycles, HI/LO unchanged.
- mult followed immediately by mflo in D. Required: md_stall high cycles 0–5; mflo reads the new LO in cycle 6. Also mthi 0x1234 with req=1. Required: HI unchanged.
- div started, then req=1 at cycle 3. Required: completes at cycle 11 with correct HI/LO; a new div presented with req=1 never starts.
- reset asserted asynchronously at cycle 4 of a div. Required: busy=0, HI=LO=0 immediately; no HI/LO update at cycle 11.
